// File: rtl/pa_pkg.sv
// rtl/pa_pkg.sv - shared constants for the add-pipeline hazard controller
package pa_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_EX = 2'b01;
  localparam logic [1:0] FWD_WB = 2'b10;

  localparam logic NOP_VLD = 1'b0;
  localparam logic NOP_WE  = 1'b0;

  // The younger producer (EX) holds the newer value, so it wins over WB.
  function automatic logic [1:0] fwd_pick(input logic hit_ex, input logic hit_wb);
    logic [1:0] s;
    s = FWD_RF;
    if (hit_wb) s = FWD_WB;
    if (hit_ex) s = FWD_EX;
    return s;
  endfunction

endpackage

// File: rtl/pa_hazard_cmp.sv
// rtl/pa_hazard_cmp.sv - RAW match of one ID source operand against EX and WB
module pa_hazard_cmp
  import pa_pkg::*;
#(
  parameter int RW = 5
) (
  input  logic [RW-1:0] src,
  input  logic          valid_ex,
  input  logic          we_ex,
  input  logic [RW-1:0] rd_ex,
  input  logic          valid_wb,
  input  logic          we_wb,
  input  logic [RW-1:0] rd_wb,
  output logic          hit_ex,
  output logic          hit_wb,
  output logic [1:0]    sel
);

  // r0 is hard-wired, so it never carries a dependency
  assign hit_ex = valid_ex & we_ex & (rd_ex == src) & (src != '0);
  assign hit_wb = valid_wb & we_wb & (rd_wb == src) & (src != '0);
  assign sel    = fwd_pick(hit_ex, hit_wb);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - start/halt sequencer, stage trackers and RAW hazard control
module pipe_hazard_ctrl
  import pa_pkg::*;
#(
  parameter int RW     = 5,
  parameter bit FWD_EN = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt_req,
  input  logic             instr_vld,
  input  logic [RW-1:0]    id_rs,
  input  logic [RW-1:0]    id_rt,
  input  logic [RW-1:0]    id_rd,
  input  logic             id_we,
  output logic             if_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             ex_bubble,
  output logic             exwb_en,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             wb_en,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [1:0]       state;
  logic             valid_id, valid_ex, we_ex, valid_wb, we_wb;
  logic [RW-1:0]    rd_ex, rd_wb;
  logic [CNT_W-1:0] stall_q;
  logic             run, active, stall;
  logic             a_hit_ex, a_hit_wb, b_hit_ex, b_hit_wb;
  logic [1:0]       sel_a, sel_b;

  pa_hazard_cmp #(.RW(RW)) u_cmp_a (
    .src(id_rs), .valid_ex(valid_ex), .we_ex(we_ex), .rd_ex(rd_ex),
    .valid_wb(valid_wb), .we_wb(we_wb), .rd_wb(rd_wb),
    .hit_ex(a_hit_ex), .hit_wb(a_hit_wb), .sel(sel_a)
  );

  pa_hazard_cmp #(.RW(RW)) u_cmp_b (
    .src(id_rt), .valid_ex(valid_ex), .we_ex(we_ex), .rd_ex(rd_ex),
    .valid_wb(valid_wb), .we_wb(we_wb), .rd_wb(rd_wb),
    .hit_ex(b_hit_ex), .hit_wb(b_hit_wb), .sel(sel_b)
  );

  assign run    = (state == ST_RUN);
  assign active = run | (state == ST_DRAIN);
  assign stall  = active & (FWD_EN == 1'b0) & valid_id
                & (a_hit_ex | a_hit_wb | b_hit_ex | b_hit_wb);

  assign if_en     = run & ~stall;
  assign ifid_en   = active & ~stall;
  assign idex_en   = active;
  assign ex_bubble = stall;
  assign exwb_en   = active;
  assign fwd_a     = (FWD_EN == 1'b1) ? sel_a : FWD_RF;
  assign fwd_b     = (FWD_EN == 1'b1) ? sel_b : FWD_RF;
  assign wb_en     = active & valid_wb & we_wb;
  assign busy      = active;
  assign halted    = (state == ST_HALTED);
  assign stall_cnt = stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      valid_id <= 1'b0;
      valid_ex <= 1'b0;
      we_ex    <= 1'b0;
      rd_ex    <= '0;
      valid_wb <= 1'b0;
      we_wb    <= 1'b0;
      rd_wb    <= '0;
      stall_q  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_HALTED: if (start && !halt_req) state <= ST_RUN;
        ST_RUN:             if (halt_req) state <= ST_DRAIN;
        ST_DRAIN:           if (!(valid_id || valid_ex || valid_wb)) state <= ST_HALTED;
        default:            state <= ST_IDLE;
      endcase

      // In DRAIN if_en is low, so IF/ID keeps loading empty slots
      if (ifid_en) valid_id <= if_en & instr_vld;

      if (idex_en) begin
        if (stall) begin
          valid_ex <= NOP_VLD;
          we_ex    <= NOP_WE;
          rd_ex    <= '0;
        end else begin
          valid_ex <= valid_id;
          we_ex    <= valid_id & id_we;
          rd_ex    <= id_rd;
        end
      end

      if (exwb_en) begin
        valid_wb <= valid_ex;
        we_wb    <= we_ex;
        rd_wb    <= rd_ex;
      end

      if (stall && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl, forwarding and stalling builds
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       we;
  } ins_t;

  typedef struct {
    int         l;
    logic [4:0] rd;
    logic       we;
  } hist_t;

  typedef struct {
    int         c;
    logic [1:0] a;
    logic [1:0] b;
  } efwd_t;

  logic        clk = 1'b0;
  logic        rst_n, start, halt_req;
  logic        instr_vld [2];
  logic [4:0]  id_rs [2], id_rt [2], id_rd [2];
  logic        id_we [2];
  logic        if_en [2], ifid_en [2], idex_en [2], ex_bubble [2], exwb_en [2];
  logic        wb_en [2], busy [2], halted [2];
  logic [1:0]  fwd_a [2], fwd_b [2];
  logic [15:0] stall_cnt [2];

  int   total = 0;
  int   bad = 0;
  ins_t prog[$];
  int   pc [2];
  int   pend [2];
  int   exp_stalls [2];
  int   gap_pct = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit wr(input hist_t p, input logic [4:0] s);
    return p.we && (p.rd == s) && (s != 5'd0);
  endfunction

  // A producer that left ID one cycle before the consumer sits in EX, two cycles before in WB
  function automatic logic [1:0] fwd_of(input hist_t h[$], input int l, input logic [4:0] s);
    bit ex = 1'b0;
    bit wb = 1'b0;
    foreach (h[j]) begin
      if (wr(h[j], s) && h[j].l == l - 1) ex = 1'b1;
      if (wr(h[j], s) && h[j].l == l - 2) wb = 1'b1;
    end
    return ex ? 2'b01 : (wb ? 2'b10 : 2'b00);
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_dut
    localparam bit FWD = (k == 0);

    pipe_hazard_ctrl #(.RW(5), .FWD_EN(FWD), .CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
      .instr_vld(instr_vld[k]), .id_rs(id_rs[k]), .id_rt(id_rt[k]),
      .id_rd(id_rd[k]), .id_we(id_we[k]),
      .if_en(if_en[k]), .ifid_en(ifid_en[k]), .idex_en(idex_en[k]),
      .ex_bubble(ex_bubble[k]), .exwb_en(exwb_en[k]),
      .fwd_a(fwd_a[k]), .fwd_b(fwd_b[k]), .wb_en(wb_en[k]),
      .busy(busy[k]), .halted(halted[k]), .stall_cnt(stall_cnt[k])
    );

    hist_t hist[$];
    int    exp_wb[$];
    efwd_t exp_fwd[$];
    bit    stall_at[int];
    int    last_l, cyc, e, l;
    ins_t  cur;
    bit    fetch, ld;
    logic [1:0] ea, eb;

    // Environment: plays the IF/ID register and the fetch source, and keeps the reference model
    initial begin
      cyc = 0; last_l = -10; pc[k] = 0; pend[k] = 0; exp_stalls[k] = 0;
      id_rs[k] = '0; id_rt[k] = '0; id_rd[k] = '0; id_we[k] = 1'b0; instr_vld[k] = 1'b0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          hist.delete(); exp_wb.delete(); exp_fwd.delete(); stall_at.delete();
          last_l = -10; pc[k] = 0; pend[k] = 0; exp_stalls[k] = 0;
          id_rs[k] = '0; id_rt[k] = '0; id_rd[k] = '0; id_we[k] = 1'b0; instr_vld[k] = 1'b0;
          continue;
        end

        if (exp_wb.size() > 0 && exp_wb[0] == cyc) begin
          chk($sformatf("wb_en_due[%0d] c%0d", k, cyc), int'(wb_en[k]), 1);
          void'(exp_wb.pop_front());
        end else if (wb_en[k]) begin
          chk($sformatf("wb_en_unexpected[%0d] c%0d", k, cyc), 1, 0);
        end
        if (exp_fwd.size() > 0 && exp_fwd[0].c == cyc) begin
          chk($sformatf("fwd_a[%0d] c%0d", k, cyc), int'(fwd_a[k]), int'(exp_fwd[0].a));
          chk($sformatf("fwd_b[%0d] c%0d", k, cyc), int'(fwd_b[k]), int'(exp_fwd[0].b));
          void'(exp_fwd.pop_front());
        end
        if (ex_bubble[k] || stall_at.exists(cyc)) begin
          chk($sformatf("ex_bubble[%0d] c%0d", k, cyc), int'(ex_bubble[k]), int'(stall_at.exists(cyc)));
          chk($sformatf("if_en_stall[%0d] c%0d", k, cyc), int'(if_en[k]), int'(!stall_at.exists(cyc)));
          stall_at.delete(cyc);
        end

        fetch = if_en[k] && instr_vld[k];
        ld    = ifid_en[k];
        if (fetch) begin
          cur = prog[pc[k]];
          pc[k]++;
          e = cyc + 1;
          l = (e > last_l + 1) ? e : last_l + 1;
          if (!FWD) begin
            foreach (hist[j])
              if ((wr(hist[j], cur.rs) || wr(hist[j], cur.rt)) && hist[j].l + 3 > l)
                l = hist[j].l + 3;
          end
          for (int x = e; x < l; x++) stall_at[x] = 1'b1;
          exp_stalls[k] += l - e;
          ea = FWD ? fwd_of(hist, l, cur.rs) : 2'b00;
          eb = FWD ? fwd_of(hist, l, cur.rt) : 2'b00;
          exp_fwd.push_back('{l, ea, eb});
          if (cur.we) exp_wb.push_back(l + 2);
          hist.push_back('{l, cur.rd, cur.we});
          if (hist.size() > 4) void'(hist.pop_front());
          last_l = l;
        end
        pend[k] = exp_wb.size() + exp_fwd.size();

        @(posedge clk);
        #1;
        cyc++;
        if (rst_n && ld) begin
          id_rs[k] = fetch ? cur.rs : 5'd0;
          id_rt[k] = fetch ? cur.rt : 5'd0;
          id_rd[k] = fetch ? cur.rd : 5'd0;
          id_we[k] = fetch ? cur.we : 1'b0;
        end
        instr_vld[k] = (pc[k] < prog.size()) && ($urandom_range(99) >= gap_pct);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int rs, input int rt, input int rd, input bit we);
    prog.push_back({5'(rs), 5'(rt), 5'(rd), we});
  endtask

  task automatic push_rand(input int n);
    for (int i = 0; i < n; i++)
      push($urandom_range(3), $urandom_range(3), $urandom_range(3), 1'($urandom_range(1)));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycles(1);
    start = 1'b0;
  endtask

  task automatic pulse_halt();
    halt_req = 1'b1;
    cycles(1);
    halt_req = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int bound);
    int n = 0;
    while (!(pc[0] == prog.size() && pc[1] == prog.size() && pend[0] == 0 && pend[1] == 0)
           && n < bound) begin
      cycles(1);
      n++;
    end
    chk({tag, "_drain_in_time"}, int'(n < bound), 1);
  endtask

  task automatic wait_halted(input string tag, input int bound);
    int n = 0;
    while (!(halted[0] && halted[1]) && n < bound) begin
      cycles(1);
      n++;
    end
    chk({tag, "_halt_in_time"}, int'(n < bound), 1);
  endtask

  task automatic check_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_if_en[%0d]", tag, k), int'(if_en[k]), 0);
      chk($sformatf("%s_ifid_en[%0d]", tag, k), int'(ifid_en[k]), 0);
      chk($sformatf("%s_idex_en[%0d]", tag, k), int'(idex_en[k]), 0);
      chk($sformatf("%s_ex_bubble[%0d]", tag, k), int'(ex_bubble[k]), 0);
      chk($sformatf("%s_exwb_en[%0d]", tag, k), int'(exwb_en[k]), 0);
      chk($sformatf("%s_fwd[%0d]", tag, k), int'({fwd_a[k], fwd_b[k]}), 0);
      chk($sformatf("%s_wb_en[%0d]", tag, k), int'(wb_en[k]), 0);
      chk($sformatf("%s_busy[%0d]", tag, k), int'(busy[k]), 0);
      chk($sformatf("%s_halted[%0d]", tag, k), int'(halted[k]), 0);
      chk($sformatf("%s_stall_cnt[%0d]", tag, k), int'(stall_cnt[k]), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; halt_req = 1'b0;
    cycles(2);
    check_zero("reset");
    rst_n = 1'b1;
    cycles(2);
    chk("idle_busy", int'(busy[0] | busy[1]), 0);
    pulse_start();
    chk("start_busy0", int'(busy[0]), 1);
    chk("start_busy1", int'(busy[1]), 1);

    // back-to-back dependency on rs
    push(1, 2, 3, 1'b1);
    push(3, 5, 4, 1'b1);
    wait_drain("dep_ex", 50);
    chk("dep_ex_stall_cnt_fwd", int'(stall_cnt[0]), 0);
    chk("dep_ex_stall_cnt_stl", int'(stall_cnt[1]), 2);

    // one-apart dependency on rt, then EX and WB both writing r3
    push(1, 2, 3, 1'b1);
    push(0, 0, 0, 1'b0);
    push(6, 3, 7, 1'b1);
    push(1, 1, 3, 1'b1);
    push(1, 1, 3, 1'b1);
    push(2, 3, 8, 1'b1);
    wait_drain("dep_wb", 80);

    // r0 as destination and source
    push(1, 2, 0, 1'b1);
    push(0, 4, 5, 1'b1);
    wait_drain("dep_r0", 50);
    chk("dep_r0_stall_cnt_fwd", int'(stall_cnt[0]), 0);

    // halt with three instructions in flight, then resume
    for (int i = 0; i < 6; i++) push(20, 21, 10 + i, 1'b1);
    begin
      int n = 0;
      while (pc[0] < 3 && n < 50) begin cycles(1); n++; end
      chk("halt_reach_fill", int'(n < 50), 1);
    end
    pulse_halt();
    chk("halt_if_en0", int'(if_en[0]), 0);
    chk("halt_if_en1", int'(if_en[1]), 0);
    wait_halted("halt3", 50);
    chk("halt3_pending0", pend[0], 0);
    chk("halt3_pending1", pend[1], 0);
    chk("halt3_busy0", int'(busy[0]), 0);
    pulse_start();
    chk("resume_busy0", int'(busy[0]), 1);
    chk("resume_busy1", int'(busy[1]), 1);
    wait_drain("resume", 60);

    // randomized traffic with fetch gaps and halt/resume cycles
    gap_pct = 30;
    for (int r = 0; r < 4; r++) begin
      push_rand(60);
      cycles(20 + $urandom_range(40));
      pulse_halt();
      wait_halted($sformatf("rand%0d", r), 200);
      pulse_start();
    end
    wait_drain("rand", 3000);
    chk("rand_stall_cnt_fwd", int'(stall_cnt[0]), exp_stalls[0]);
    chk("rand_stall_cnt_stl", int'(stall_cnt[1]), exp_stalls[1]);

    // asynchronous reset in the middle of RUN
    gap_pct = 0;
    push_rand(40);
    cycles(12);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("mid_reset");
    @(negedge clk);
    @(negedge clk);
    prog.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycles(6);
    chk("post_reset_busy0", int'(busy[0]), 0);
    chk("post_reset_busy1", int'(busy[1]), 0);
    pulse_start();
    chk("post_reset_start0", int'(busy[0]), 1);
    push_rand(30);
    wait_drain("post_reset", 400);
    chk("post_reset_stall_cnt_fwd", int'(stall_cnt[0]), exp_stalls[0]);
    chk("post_reset_stall_cnt_stl", int'(stall_cnt[1]), exp_stalls[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
